// File: rtl/posit_norm_round.sv
// Two-stage normalize/round/saturate pipeline for posit significands.
// Stage 1 shifts out leading zeros; stage 2 rounds to nearest-even and clamps the scale.
module posit_norm_round #(
  parameter int W_OUT     = 12,
  parameter int SCALE_MAX = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_mant,
  input  logic [3:0]        in_lzc,
  input  logic              in_zero,
  input  logic [7:0]        in_scale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_OUT-1:0]  out_mant,
  output logic [7:0]        out_scale,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);

  localparam logic signed [8:0] SAT_HI      = 9'(SCALE_MAX);
  localparam logic signed [8:0] SAT_LO      = 9'(-SCALE_MAX);
  localparam logic [15:0]       STICKY_MASK = 16'((32'd1 << (15 - W_OUT)) - 32'd1);
  localparam logic [W_OUT-1:0]  MANT_MIN    = {1'b1, {(W_OUT-1){1'b0}}};

  logic              s1_valid;
  logic [15:0]       s1_mant;
  logic signed [8:0] s1_diff;
  logic              s1_zero;

  logic              s2_advance;
  logic [15:0]       s_shift;
  logic signed [8:0] diff;

  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  assign s_shift = in_mant << in_lzc;
  // Scale minus shift kept at 9 bits so -128 - 15 cannot wrap.
  assign diff    = $signed({in_scale[7], in_scale}) - $signed({5'b0, in_lzc});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_diff  <= '0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= s_shift;
        s1_diff <= diff;
        s1_zero <= in_zero;
      end
    end
  end

  logic [W_OUT-1:0]  keep;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic              carry;
  logic [W_OUT-1:0]  mant_rnd;
  logic signed [8:0] t;

  logic [W_OUT-1:0]  mant_next;
  logic [7:0]        scale_next;
  logic              zero_next;
  logic              ovf_next;
  logic              unf_next;

  always_comb begin
    keep     = s1_mant[15 -: W_OUT];
    guard    = s1_mant[15 - W_OUT];
    sticky   = |(s1_mant & STICKY_MASK);
    round_up = guard & (sticky | keep[0]);
    carry    = round_up & (&keep);
    mant_rnd = carry ? MANT_MIN : keep + W_OUT'(round_up);
    t        = s1_diff + $signed({8'b0, carry});

    mant_next  = mant_rnd;
    scale_next = t[7:0];
    zero_next  = 1'b0;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;

    if (s1_zero) begin
      mant_next  = '0;
      scale_next = '0;
      zero_next  = 1'b1;
    end else if (t > SAT_HI) begin
      mant_next  = '1;
      scale_next = SAT_HI[7:0];
      ovf_next   = 1'b1;
    end else if (t < SAT_LO) begin
      mant_next  = MANT_MIN;
      scale_next = SAT_LO[7:0];
      unf_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_scale <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mant  <= mant_next;
        out_scale <= scale_next;
        out_zero  <= zero_next;
        out_ovf   <= ovf_next;
        out_unf   <= unf_next;
      end
    end
  end

endmodule

// File: tb/tb_posit_norm_round.sv
// Bench for posit_norm_round: directed vectors, backpressure, mid-stream reset,
// and randomized traffic scored against an arithmetic reference model.
module tb_posit_norm_round;
  localparam int W    = 12;
  localparam int SMAX = 120;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [15:0]  in_mant;
  logic [3:0]   in_lzc;
  logic         in_zero;
  logic [7:0]   in_scale;
  logic         out_valid, out_ready;
  logic [W-1:0] out_mant;
  logic [7:0]   out_scale;
  logic         out_zero, out_ovf, out_unf;

  always #5 clk = ~clk;

  posit_norm_round #(.W_OUT(W), .SCALE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_lzc(in_lzc), .in_zero(in_zero), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_scale(out_scale),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  typedef struct packed {
    logic [W-1:0] mant;
    logic [7:0]   scale;
    logic         zero;
    logic         ovf;
    logic         unf;
  } res_t;

  typedef struct {
    logic [15:0] mant;
    logic [3:0]  lzc;
    logic        zero;
    logic [7:0]  scale;
    res_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sb_on    = 1'b0;
  int   pops     = 0;
  res_t exp_q[$];
  res_t cur;

  assign cur = {out_mant, out_scale, out_zero, out_ovf, out_unf};

  // Reference: integer split into kept value and remainder, compared against half an ulp.
  function automatic res_t model(input logic [15:0] m, input logic [3:0] lzc,
                                 input logic z, input logic [7:0] sc);
    res_t r;
    int s, keep, rem, half, t;
    r = '0;
    if (z) begin
      r.zero = 1'b1;
      return r;
    end
    s    = (int'(m) << lzc) % 65536;
    keep = s / (1 << (16 - W));
    rem  = s % (1 << (16 - W));
    half = 1 << (15 - W);
    t    = int'($signed(sc)) - int'(lzc);
    if (rem > half || (rem == half && keep % 2 == 1)) keep++;
    if (keep == (1 << W)) begin
      keep = 1 << (W - 1);
      t++;
    end
    if (t > SMAX) begin
      r.mant = '1; r.scale = 8'(SMAX); r.ovf = 1'b1;
    end else if (t < -SMAX) begin
      r.mant = W'(1 << (W - 1)); r.scale = 8'(-SMAX); r.unf = 1'b1;
    end else begin
      r.mant = W'(keep); r.scale = 8'(t);
    end
    return r;
  endfunction

  function automatic logic [3:0] lzc_of(input logic [15:0] m);
    int n = 0;
    for (int b = 15; b >= 0; b--) begin
      if (m[b]) break;
      n++;
    end
    return 4'(n);
  endfunction

  function automatic vec_t mk(input logic [15:0] m, input logic [3:0] l, input logic z,
                              input logic [7:0] sc, input logic [W-1:0] em, input logic [7:0] es,
                              input logic ez, input logic eo, input logic eu);
    vec_t v;
    v.mant = m; v.lzc = l; v.zero = z; v.scale = sc;
    v.exp  = {em, es, ez, eo, eu};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    logic [15:0] m;
    if ($urandom % 16 == 0) begin
      in_zero = 1'b1;
      in_mant = '0;
      in_lzc  = 4'($urandom);
    end else begin
      m = 16'($urandom) >> $urandom_range(0, 15);
      if (m == 0) m = 16'd1;
      in_zero = 1'b0;
      in_mant = m;
      in_lzc  = lzc_of(m);
    end
    in_scale = 8'($urandom);
  endtask

  // Scoreboard, hold-while-stalled check and reset flush, sampled mid-cycle.
  res_t held;
  bit   stalled = 1'b0;
  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else if (sb_on) begin
      if (stalled) check("stall_hold", {out_valid, cur}, {1'b1, held});
      stalled = out_valid && !out_ready;
      held    = cur;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 64'(cur), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", cur, e);
          pops++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_mant, in_lzc, in_zero, in_scale));
    end else begin
      stalled = 1'b0;
    end
  end

  vec_t        tbl[13];
  logic [15:0] bp_mant[5];
  logic [3:0]  bp_lzc[5];
  logic        bp_zero[5];
  logic [7:0]  bp_scale[5];
  res_t        exp_c;

  initial begin
    int idx, pops0;
    bit acc;

    tbl[0]  = mk(16'h0010, 4'd11, 1'b0, 8'h00, 12'h800, 8'hF5, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(16'h8018, 4'd0,  1'b0, 8'h00, 12'h802, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(16'h8008, 4'd0,  1'b0, 8'h00, 12'h800, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(16'hFFF8, 4'd0,  1'b0, 8'h05, 12'h800, 8'h06, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(16'hFFF8, 4'd0,  1'b0, 8'h78, 12'hFFF, 8'h78, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(16'h1000, 4'd3,  1'b0, 8'h8A, 12'h800, 8'h88, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(16'h0000, 4'd5,  1'b1, 8'h4D, 12'h000, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(16'h8019, 4'd0,  1'b0, 8'h00, 12'h802, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(16'h8017, 4'd0,  1'b0, 8'h00, 12'h801, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(16'h0001, 4'd15, 1'b0, 8'h97, 12'h800, 8'h88, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(16'hFFF8, 4'd0,  1'b0, 8'h77, 12'h800, 8'h78, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(16'h0002, 4'd14, 1'b0, 8'h80, 12'h800, 8'h88, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(16'h7FFF, 4'd1,  1'b0, 8'h00, 12'h800, 8'h00, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_lzc = '0; in_zero = 1'b0;
    in_scale = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", cur, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Directed vectors, one at a time, with latency checked.
    foreach (tbl[i]) begin
      in_valid = 1'b1;
      in_mant = tbl[i].mant; in_lzc = tbl[i].lzc; in_zero = tbl[i].zero; in_scale = tbl[i].scale;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_lat1", i), out_valid, 0);
      step();
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_data", i), cur, tbl[i].exp);
      $display("vec%0d mant=%h lzc=%0d zero=%b scale=%h -> out_mant=%h out_scale=%h z/o/u=%b%b%b",
               i, tbl[i].mant, tbl[i].lzc, tbl[i].zero, tbl[i].scale,
               out_mant, out_scale, out_zero, out_ovf, out_unf);
    end
    step();

    // Backpressure: five beats offered back-to-back, sink stalled for 4 cycles.
    for (int i = 0; i < 5; i++) begin
      rand_beat();
      bp_mant[i] = in_mant; bp_lzc[i] = in_lzc; bp_zero[i] = in_zero; bp_scale[i] = in_scale;
    end
    sb_on = 1'b1;
    pops0 = pops;
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc >= 4);
      if (idx < 5) begin
        in_valid = 1'b1;
        in_mant = bp_mant[idx]; in_lzc = bp_lzc[idx]; in_zero = bp_zero[idx]; in_scale = bp_scale[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (cyc == 2) begin
        check("bp_in_ready_low", in_ready, 0);
        check("bp_accepted_before_stall", idx, 2);
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx == 5 && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 5);
    check("bp_emitted", pops - pops0, 5);
    sb_on = 1'b0;
    out_ready = 1'b1;
    step();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; rand_beat();
    step();
    rand_beat();
    step();
    in_valid = 1'b0;
    check("mid_two_in_flight", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_outputs", cur, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_rst_no_ghost", out_valid, 0);
    in_valid = 1'b1;
    rand_beat();
    exp_c = model(in_mant, in_lzc, in_zero, in_scale);
    step();
    in_valid = 1'b0;
    check("post_rst_lat1", out_valid, 0);
    step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", cur, exp_c);
    step();
    check("post_rst_single", out_valid, 0);

    // Randomized traffic with random source and sink throttling.
    sb_on = 1'b1;
    pops0 = pops;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      rand_beat();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("rand_drain_empty", exp_q.size(), 0);
    $display("random: %0d beats scored", pops - pops0);
    step();
    check("rand_idle", out_valid, 0);
    sb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
